// File: rtl/dot_product_mac_if.sv
// Operand-in / result-out handshake bundle for dot_product_mac.
// The slave modport is the MAC stage; master is whoever feeds it and consumes its results.
interface dot_product_mac_if #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 10
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/dot_product_mac.sv
// Sequential unsigned multiply-accumulate: K_LEN accepted operand pairs form one held dot-product result.
// Optional feature macro DOT_SAT_EN: clamp to all-ones on overflow instead of wrapping.
module dot_product_mac #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 10,
  parameter int K_LEN  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  dot_product_mac_if.slave  bus
);

  localparam int CNT_W = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    sum_q;
  logic                ovf_q;
  logic                valid_q;

  logic [2*DATA_W-1:0] prod_d;
  logic [ACC_W-1:0]    base_d;
  logic [ACC_W:0]      nxt_d;
  logic [ACC_W-1:0]    res_d;
  logic                ovf_d;
  logic                accept;

  // in_ready comes from the state register alone, so no input reaches it combinationally.
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = ovf_q;

  assign accept = bus.in_valid && (state_q == ACCUM);

  always_comb begin
    prod_d = '0;
    base_d = '0;
    nxt_d  = '0;
    res_d  = '0;
    ovf_d  = 1'b0;
    prod_d = {{DATA_W{1'b0}}, bus.a_in} * {{DATA_W{1'b0}}, bus.b_in};
    // cnt==0 starts a fresh vector, so stale acc/ovf from an earlier or aborted vector is ignored.
    base_d = (cnt_q == '0) ? '0 : acc_q;
    nxt_d  = {1'b0, base_d} + (ACC_W+1)'(prod_d);
`ifdef DOT_SAT_EN
    res_d  = nxt_d[ACC_W] ? '1 : nxt_d[ACC_W-1:0];
`else
    res_d  = nxt_d[ACC_W-1:0];
`endif
    ovf_d  = ((cnt_q == '0) ? 1'b0 : ovf_q) | nxt_d[ACC_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (clr) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            ovf_q <= ovf_d;
            if (cnt_q == CNT_LAST) begin
              sum_q   <= res_d;
              cnt_q   <= '0;
              state_q <= HOLD;
              valid_q <= 1'b1;
            end else begin
              acc_q <= res_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q <= ACCUM;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ACCUM;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_product_mac.sv
// Directed bench for dot_product_mac: a K_LEN=4 instance for the main vectors and a K_LEN=5 one for overflow.
module tb_dot_product_mac;

  logic clk;
  logic rst_n;
  logic clr0;
  logic clr5;
  int   n_cmp;
  int   n_err;

  dot_product_mac_if #(.DATA_W(4), .ACC_W(10)) if0 ();
  dot_product_mac_if #(.DATA_W(4), .ACC_W(10)) if5 ();

  dot_product_mac #(.DATA_W(4), .ACC_W(10), .K_LEN(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr0),
    .bus   (if0.slave)
  );

  dot_product_mac #(.DATA_W(4), .ACC_W(10), .K_LEN(5)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr5),
    .bus   (if5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [3:0] a, input logic [3:0] b);
    if0.in_valid = 1'b1;
    if0.a_in     = a;
    if0.b_in     = b;
    step();
    if0.in_valid = 1'b0;
  endtask

  task automatic send5(input logic [3:0] a, input logic [3:0] b);
    if5.in_valid = 1'b1;
    if5.a_in     = a;
    if5.b_in     = b;
    step();
    if5.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr0  = 1'b0;
    clr5  = 1'b0;
    if0.in_valid = 1'b0; if0.a_in = '0; if0.b_in = '0; if0.out_ready = 1'b0;
    if5.in_valid = 1'b0; if5.a_in = '0; if5.b_in = '0; if5.out_ready = 1'b0;

    #3;
    chk("rst_valid", 32'(if0.out_valid), 0);
    chk("rst_sum",   32'(if0.out_sum),   0);
    chk("rst_ovf",   32'(if0.out_ovf),   0);
    #9 rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(if0.in_ready), 1);

    // Test 1: 1*2+3*4+5*6+7*8 = 100
    if0.out_ready = 1'b1;
    send0(4'd1, 4'd2);
    send0(4'd3, 4'd4);
    send0(4'd5, 4'd6);
    chk("t1_no_early_valid", 32'(if0.out_valid), 0);
    send0(4'd7, 4'd8);
    chk("t1_valid", 32'(if0.out_valid), 1);
    chk("t1_in_ready_low", 32'(if0.in_ready), 0);
    chk("t1_sum", 32'(if0.out_sum), 100);
    chk("t1_ovf", 32'(if0.out_ovf), 0);
    step();
    chk("t1_released_valid", 32'(if0.out_valid), 0);
    chk("t1_released_ready", 32'(if0.in_ready), 1);

    // Test 2: 4*225 = 900 held under back-pressure; offered beats are refused
    if0.out_ready = 1'b0;
    repeat (4) send0(4'd15, 4'd15);
    if0.in_valid = 1'b1; if0.a_in = 4'd1; if0.b_in = 4'd1;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(if0.out_valid), 1);
      chk("t2_hold_ready", 32'(if0.in_ready), 0);
      chk("t2_hold_sum",   32'(if0.out_sum), 900);
      step();
    end
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    step();
    chk("t2_release_valid", 32'(if0.out_valid), 0);
    chk("t2_release_ready", 32'(if0.in_ready), 1);
    if0.out_ready = 1'b0;

    // Test 3: K_LEN=5, 5*225 = 1125 overflows 10 bits
    repeat (5) send5(4'd15, 4'd15);
    chk("t3_valid", 32'(if5.out_valid), 1);
`ifdef DOT_SAT_EN
    chk("t3_sum_sat", 32'(if5.out_sum), 1023);
`else
    chk("t3_sum_wrap", 32'(if5.out_sum), 101);
`endif
    chk("t3_ovf", 32'(if5.out_ovf), 1);
    if5.out_ready = 1'b1;
    step();
    chk("t3_release", 32'(if5.out_valid), 0);
    if5.out_ready = 1'b0;

    // Test 4: clr drops the coincident beat and the partial vector
    send0(4'd2, 4'd3);
    send0(4'd2, 4'd3);
    clr0 = 1'b1;
    send0(4'd2, 4'd3);
    clr0 = 1'b0;
    chk("t4_clr_valid", 32'(if0.out_valid), 0);
    chk("t4_clr_ovf",   32'(if0.out_ovf), 0);
    chk("t4_clr_ready", 32'(if0.in_ready), 1);
    send0(4'd1, 4'd1);
    send0(4'd1, 4'd1);
    send0(4'd1, 4'd1);
    chk("t4_no_early_valid", 32'(if0.out_valid), 0);
    send0(4'd1, 4'd1);
    chk("t4_valid", 32'(if0.out_valid), 1);
    chk("t4_sum", 32'(if0.out_sum), 4);
    // clr in HOLD wins over out_ready=0 and drops the result
    clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    chk("t4_clr_hold", 32'(if0.out_valid), 0);

    // Test 5: gaps with junk operands while in_valid=0
    if0.a_in = 4'd15; if0.b_in = 4'd15;
    send0(4'd1, 4'd1);
    if0.a_in = 4'd15; if0.b_in = 4'd15;
    step(); step();
    send0(4'd2, 4'd2);
    step();
    send0(4'd3, 4'd3);
    if0.a_in = 4'd9; if0.b_in = 4'd9;
    step(); step();
    chk("t5_gap_no_valid", 32'(if0.out_valid), 0);
    send0(4'd4, 4'd4);
    chk("t5_valid", 32'(if0.out_valid), 1);
    chk("t5_sum", 32'(if0.out_sum), 30);
    if0.out_ready = 1'b1;
    step();
    if0.out_ready = 1'b0;
    chk("t5_release", 32'(if0.out_valid), 0);

    // Test 6: async reset mid-vector, not aligned to the clock
    send0(4'd1, 4'd1);
    send0(4'd1, 4'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_sum",   32'(if0.out_sum), 0);
    chk("t6_rst_valid", 32'(if0.out_valid), 0);
    chk("t6_rst_ovf",   32'(if0.out_ovf), 0);
    #9 rst_n = 1'b1;
    step();
    chk("t6_ready", 32'(if0.in_ready), 1);
    send0(4'd1, 4'd1);
    send0(4'd1, 4'd1);
    send0(4'd1, 4'd1);
    chk("t6_no_early_valid", 32'(if0.out_valid), 0);
    send0(4'd1, 4'd1);
    chk("t6_valid", 32'(if0.out_valid), 1);
    chk("t6_sum", 32'(if0.out_sum), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
